// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit-select encodings and the execute sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] SEL_ADDSUB = 3'b000;
    localparam logic [2:0] SEL_MUL    = 3'b001;
    localparam logic [2:0] SEL_DIV    = 3'b010;
    localparam logic [2:0] SEL_SLL    = 3'b011;
    localparam logic [2:0] SEL_SRL    = 3'b100;
    localparam logic [2:0] SEL_XOR    = 3'b101;
    localparam logic [2:0] SEL_OR     = 3'b110;
    localparam logic [2:0] SEL_AND    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer: holds ALU inputs stable for the op latency, then
// presents the captured result downstream over a valid/ready handshake.
//
// state | meaning
// IDLE  | no operation held; ready to accept
// EXEC  | ALU inputs held, counting down the op latency
// DONE  | result valid, waiting for downstream to take it
module alu_exec_sequencer
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH         = 64,
    parameter int ALU_CONTROL_WIDTH = 2,
    parameter int ALU_SELECT_WIDTH  = 3,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int DIV_CYCLES        = 64,
    parameter logic [ALU_SELECT_WIDTH-1:0] DIV_SELECT = ALU_SELECT_WIDTH'(SEL_DIV)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BUS_WIDTH-1:0]         in_op1,
    input  logic [BUS_WIDTH-1:0]         in_op2,
    input  logic [ALU_CONTROL_WIDTH-1:0] in_control,
    input  logic [ALU_SELECT_WIDTH-1:0]  in_select,
    input  logic [REG_ADDR_WIDTH-1:0]    in_rd,
    output logic [BUS_WIDTH-1:0]         alu_in1,
    output logic [BUS_WIDTH-1:0]         alu_in2,
    output logic [ALU_CONTROL_WIDTH-1:0] alu_control,
    output logic [ALU_SELECT_WIDTH-1:0]  alu_select,
    input  logic [BUS_WIDTH-1:0]         alu_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BUS_WIDTH-1:0]         out_result,
    output logic [REG_ADDR_WIDTH-1:0]    out_rd,
    output logic                         busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    seq_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic accept, cnt_zero, capture;

    assign accept   = in_valid && in_ready;
    assign cnt_zero = (cnt_q == '0);
    // A completion coinciding with flush is dropped, so nothing reaches out_result.
    assign capture  = (state_q == ST_EXEC) && cnt_zero && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (accept) state_d = ST_EXEC;
                ST_EXEC: if (cnt_zero) state_d = ST_DONE;
                ST_DONE: if (out_ready) state_d = accept ? ST_EXEC : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
        busy      = (state_q == ST_EXEC);
        out_valid = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_control <= '0;
            alu_select  <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            out_result  <= '0;
            out_rd      <= '0;
        end else begin
            if (flush) begin
                cnt_q <= '0;
            end else if (accept) begin
                alu_in1     <= in_op1;
                alu_in2     <= in_op2;
                alu_control <= in_control;
                alu_select  <= in_select;
                rd_q        <= in_rd;
                cnt_q       <= (in_select == DIV_SELECT) ? DIV_LOAD : '0;
            end else if ((state_q == ST_EXEC) && !cnt_zero) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (capture) begin
                out_result <= alu_out;
                out_rd     <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a behavioural ALU on its outputs.
module tb_alu_exec_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_op1 = '0, in_op2 = '0;
    logic [1:0]  in_control = '0;
    logic [2:0]  in_select = '0;
    logic [4:0]  in_rd = '0;
    logic [63:0] alu_in1, alu_in2, alu_out, out_result;
    logic [1:0]  alu_control;
    logic [2:0]  alu_select;
    logic        out_valid, busy;
    logic        out_ready = 1'b1;
    logic [4:0]  out_rd;

    int n_checks = 0;
    int n_fail = 0;

    alu_exec_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_control(in_control),
        .in_select(in_select), .in_rd(in_rd),
        .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_control(alu_control), .alu_select(alu_select),
        .alu_out(alu_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; ALUOp bit 0 selects subtract on the add/sub unit.
    always_comb begin
        alu_out = '0;
        case (alu_select)
            SEL_ADDSUB: alu_out = alu_control[0] ? alu_in1 - alu_in2 : alu_in1 + alu_in2;
            SEL_MUL:    alu_out = alu_in1 * alu_in2;
            SEL_DIV:    alu_out = (alu_in2 == '0) ? '1 : alu_in1 / alu_in2;
            SEL_SLL:    alu_out = alu_in1 << alu_in2[5:0];
            SEL_SRL:    alu_out = alu_in1 >> alu_in2[5:0];
            SEL_XOR:    alu_out = alu_in1 ^ alu_in2;
            SEL_OR:     alu_out = alu_in1 | alu_in2;
            default:    alu_out = alu_in1 & alu_in2;
        endcase
    end

    typedef struct {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [1:0]  ctl;
        logic [2:0]  sel;
        logic [4:0]  rd;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                          input logic [2:0] s, input logic [4:0] r);
        in_op1 = a; in_op2 = b; in_control = c; in_select = s; in_rd = r;
    endtask

    // Counts edges until out_valid is seen just after an edge; -1 if the budget expires.
    task automatic wait_valid(input int max, output int lat);
        lat = -1;
        for (int c = 1; c <= max; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    int lat;
    logic hold_ok, never_valid;

    initial begin
        vecs[0] = '{64'd5,    64'd7,    2'b00, SEL_ADDSUB, 5'd3,  64'd12,   1};
        vecs[1] = '{64'd100,  64'd1,    2'b01, SEL_ADDSUB, 5'd4,  64'd99,   1};
        vecs[2] = '{64'd6,    64'd7,    2'b10, SEL_MUL,    5'd5,  64'd42,   1};
        vecs[3] = '{64'd100,  64'd7,    2'b10, SEL_DIV,    5'd6,  64'd14,   64};
        vecs[4] = '{64'd1,    64'd4,    2'b10, SEL_SLL,    5'd8,  64'd16,   1};
        vecs[5] = '{64'd256,  64'd4,    2'b10, SEL_SRL,    5'd12, 64'd16,   1};
        vecs[6] = '{64'hF0,   64'hFF,   2'b10, SEL_XOR,    5'd13, 64'h0F,   1};
        vecs[7] = '{64'hF0,   64'h0F,   2'b10, SEL_OR,     5'd30, 64'hFF,   1};
        vecs[8] = '{64'hF0,   64'h3C,   2'b10, SEL_AND,    5'd31, 64'h30,   1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_alu_in1", alu_in1, 64'd0);
        check("rst_out_result", out_result, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Table-driven ops with out_ready held high
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            set_op(vecs[i].op1, vecs[i].op2, vecs[i].ctl, vecs[i].sel, vecs[i].rd);
            in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            set_op(64'hDEAD_BEEF, 64'h1234, 2'b11, 3'b111, 5'd0);
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            wait_valid(200, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_result", i), out_result, vecs[i].exp);
            check($sformatf("v%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
        end
        @(posedge clk); #1;

        // Divide with stable inputs, then back-pressure and consume+accept on one edge
        out_ready = 1'b0;
        set_op(64'd100, 64'd7, 2'b10, SEL_DIV, 5'd17);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        set_op(64'd9, 64'd9, 2'b00, SEL_ADDSUB, 5'd1);
        hold_ok = 1'b1;
        for (int c = 1; c < 64; c++) begin
            @(negedge clk);
            if (alu_in1 !== 64'd100 || alu_in2 !== 64'd7 || in_ready !== 1'b0 || out_valid !== 1'b0)
                hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        check("div_inputs_held", 64'(hold_ok), 64'd1);
        check("div_no_early_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("div_valid_at_64", 64'(out_valid), 64'd1);
        check("div_result", out_result, 64'd14);
        hold_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_result !== 64'd14 || out_rd !== 5'd17 || in_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        check("backpressure_hold", 64'(hold_ok), 64'd1);
        @(posedge clk); #1;
        set_op(64'd2, 64'd3, 2'b00, SEL_ADDSUB, 5'd9);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_consumed", 64'(out_valid), 64'd0);
        check("bp_new_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("bp_new_valid", 64'(out_valid), 64'd1);
        check("bp_new_result", out_result, 64'd5);
        check("bp_new_rd", 64'(out_rd), 64'd9);
        @(posedge clk); #1;

        // Flush in the middle of a divide with a pending op upstream
        set_op(64'd100, 64'd7, 2'b10, SEL_DIV, 5'd20);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        flush = 1'b1;
        set_op(64'd1, 64'd1, 2'b00, SEL_ADDSUB, 5'd7);
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("post_flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(100, lat);
        check("post_flush_latency", 64'(lat), 64'd1);
        check("post_flush_result", out_result, 64'd2);
        check("post_flush_rd", 64'(out_rd), 64'd7);
        never_valid = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            if (out_valid) never_valid = 1'b0;
        end
        check("flushed_div_dropped", 64'(never_valid), 64'd1);

        // Back-to-back XOR then OR
        set_op(64'hF0, 64'h0F, 2'b10, SEL_XOR, 5'd10);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_op(64'hA0, 64'h05, 2'b10, SEL_OR, 5'd11);
        @(posedge clk); #1;
        check("b2b_xor_valid", 64'(out_valid), 64'd1);
        check("b2b_xor_result", out_result, 64'hFF);
        check("b2b_xor_rd", 64'(out_rd), 64'd10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_gap", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("b2b_or_valid", 64'(out_valid), 64'd1);
        check("b2b_or_result", out_result, 64'hA5);
        check("b2b_or_rd", 64'(out_rd), 64'd11);
        @(posedge clk); #1;
        check("b2b_no_dup", 64'(out_valid), 64'd0);

        // Reset in the middle of a divide
        set_op(64'd50, 64'd5, 2'b10, SEL_DIV, 5'd2);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_alu_in1", alu_in1, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        never_valid = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            if (out_valid) never_valid = 1'b0;
        end
        check("midrst_no_result", 64'(never_valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
